// File: rtl/spi_burst_master.sv
// ============================================================================
// spi_burst_master : framed SPI register master (R/W bit, address, 1..2^BURST_WIDTH words)
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_burst_master #(
  parameter int ADDR_WIDTH   = 7,
  parameter int DATA_WIDTH   = 8,
  parameter int BURST_WIDTH  = 4,
  parameter int CLKDIV_WIDTH = 8
) (
  input  logic                    i_clock,
  input  logic                    i_resetn,
  input  logic                    i_start,
  input  logic                    i_read,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [BURST_WIDTH-1:0]  i_burstLen,
  input  logic [CLKDIV_WIDTH-1:0] i_clkDiv,
  input  logic [DATA_WIDTH-1:0]   i_wrData,
  input  logic                    i_wrValid,
  output logic                    o_wrReady,
  output logic [DATA_WIDTH-1:0]   o_rdData,
  output logic                    o_rdValid,
  output logic                    o_busy,
  output logic                    o_done,
  input  logic                    i_sout,
  output logic                    o_sen,
  output logic                    o_sck,
  output logic                    o_sdat
);

  localparam int HDR_W = ADDR_WIDTH + 1;
  localparam int SH_W  = (HDR_W > DATA_WIDTH) ? HDR_W : DATA_WIDTH;
  localparam int BC_W  = $clog2(SH_W) + 1;
  localparam logic [CLKDIV_WIDTH:0] DIV_ONE = (CLKDIV_WIDTH+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_WAITWR = 3'd2,
    S_DATA   = 3'd3,
    S_HOLD   = 3'd4,
    S_GAP    = 3'd5
  } state_t;

  state_t                  state_q,    state_d;
  logic                    read_q,     read_d;
  logic [CLKDIV_WIDTH-1:0] clkdiv_q,   clkdiv_d;
  logic [BURST_WIDTH-1:0]  word_q,     word_d;
  logic [BC_W-1:0]         bit_q,      bit_d;
  logic [CLKDIV_WIDTH:0]   div_q,      div_d;
  logic [SH_W-1:0]         shift_q,    shift_d;
  logic [DATA_WIDTH-1:0]   rx_q,       rx_d;
  logic                    sen_q,      sen_d;
  logic                    sck_q,      sck_d;
  logic                    sdat_q,     sdat_d;
  logic                    busy_q,     busy_d;
  logic                    done_q,     done_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   rd_data_q,  rd_data_d;
  logic                    wr_ready_q, wr_ready_d;

  // div counts 1..H inside each phase; one extra bit so H = 2^CLKDIV_WIDTH fits
  logic [CLKDIV_WIDTH:0] w_half;
  logic                  w_phase_end;
  assign w_half      = {1'b0, clkdiv_q} + DIV_ONE;
  assign w_phase_end = (div_q == w_half);

  always_comb begin
    state_d    = state_q;
    read_d     = read_q;
    clkdiv_d   = clkdiv_q;
    word_d     = word_q;
    bit_d      = bit_q;
    div_d      = div_q;
    shift_d    = shift_q;
    rx_d       = rx_q;
    sen_d      = sen_q;
    sck_d      = sck_q;
    sdat_d     = sdat_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    wr_ready_d = wr_ready_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          read_d   = i_read;
          clkdiv_d = i_clkDiv;
          word_d   = i_burstLen;
          bit_d    = BC_W'(HDR_W - 1);
          div_d    = DIV_ONE;
          shift_d  = '0;
          shift_d[SH_W-1 -: ADDR_WIDTH] = i_addr;
          sdat_d   = i_read;
          sen_d    = 1'b0;
          sck_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_CMD;
        end
      end

      S_CMD, S_DATA: begin
        if (!w_phase_end) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = DIV_ONE;
          if (!sck_q) begin
            sck_d = 1'b1;
            if (state_q == S_DATA && read_q) begin
              rx_d = {rx_q[DATA_WIDTH-2:0], i_sout};
              if (bit_q == '0) begin
                rd_data_d  = {rx_q[DATA_WIDTH-2:0], i_sout};
                rd_valid_d = 1'b1;
              end
            end
          end else begin
            sck_d = 1'b0;
            if (bit_q != '0) begin
              bit_d   = bit_q - 1'b1;
              sdat_d  = (state_q == S_DATA && read_q) ? 1'b0 : shift_q[SH_W-1];
              shift_d = shift_q << 1;
            end else if (state_q == S_CMD || word_q != '0) begin
              if (state_q == S_DATA) begin
                word_d = word_q - 1'b1;
              end
              if (read_q) begin
                state_d = S_DATA;
                bit_d   = BC_W'(DATA_WIDTH - 1);
                sdat_d  = 1'b0;
              end else begin
                state_d    = S_WAITWR;
                wr_ready_d = 1'b1;
              end
            end else begin
              state_d = S_HOLD;
            end
          end
        end
      end

      // The handshake cycle doubles as the first low cycle of the word's MSB,
      // so a zero-stall write costs no extra cycles.
      S_WAITWR: begin
        if (i_wrValid) begin
          wr_ready_d = 1'b0;
          sdat_d     = i_wrData[DATA_WIDTH-1];
          shift_d    = '0;
          shift_d[SH_W-1 -: DATA_WIDTH-1] = i_wrData[DATA_WIDTH-2:0];
          bit_d      = BC_W'(DATA_WIDTH - 1);
          state_d    = S_DATA;
          if (w_phase_end) begin
            sck_d = 1'b1;
            div_d = DIV_ONE;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (w_phase_end) begin
          div_d   = DIV_ONE;
          sen_d   = 1'b1;
          sdat_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_GAP;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_GAP: begin
        if (w_phase_end) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q    <= S_IDLE;
      read_q     <= 1'b0;
      clkdiv_q   <= '0;
      word_q     <= '0;
      bit_q      <= '0;
      div_q      <= DIV_ONE;
      shift_q    <= '0;
      rx_q       <= '0;
      sen_q      <= 1'b1;
      sck_q      <= 1'b0;
      sdat_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      clkdiv_q   <= clkdiv_d;
      word_q     <= word_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      rx_q       <= rx_d;
      sen_q      <= sen_d;
      sck_q      <= sck_d;
      sdat_q     <= sdat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  // MSB of an offered word is presented during the handshake cycle (SCK is low)
  assign o_sdat    = (state_q == S_WAITWR && i_wrValid) ? i_wrData[DATA_WIDTH-1] : sdat_q;
  assign o_sen     = sen_q;
  assign o_sck     = sck_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_rdValid = rd_valid_q;
  assign o_rdData  = rd_data_q;
  assign o_wrReady = wr_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_burst_master.sv
// ============================================================================
// tb_spi_burst_master : directed bench with MOSI/read-data scoreboards and SPI slave model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_spi_burst_master;

  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int BW    = 4;
  localparam int CW    = 8;
  localparam int HDR   = AW + 1;
  localparam int STALL = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start, i_read, i_wrValid, i_sout;
  logic [AW-1:0] i_addr;
  logic [BW-1:0] i_burstLen;
  logic [CW-1:0] i_clkDiv;
  logic [DW-1:0] i_wrData;
  logic          o_wrReady, o_rdValid, o_busy, o_done, o_sen, o_sck, o_sdat;
  logic [DW-1:0] o_rdData;

  always #5 clk = ~clk;

  spi_burst_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW), .CLKDIV_WIDTH(CW)
  ) dut (
    .i_clock(clk), .i_resetn(rst_n), .i_start(i_start), .i_read(i_read),
    .i_addr(i_addr), .i_burstLen(i_burstLen), .i_clkDiv(i_clkDiv),
    .i_wrData(i_wrData), .i_wrValid(i_wrValid), .o_wrReady(o_wrReady),
    .o_rdData(o_rdData), .o_rdValid(o_rdValid), .o_busy(o_busy), .o_done(o_done),
    .i_sout(i_sout), .o_sen(o_sen), .o_sck(o_sck), .o_sdat(o_sdat)
  );

  int errors = 0;
  int checks = 0;

  bit            exp_bits[$];
  logic [DW-1:0] exp_rd[$];
  bit            miso_bits[$];
  logic [DW-1:0] wr_words[$];

  logic prev_sck = 1'b0;
  bit   hs_pending = 1'b0;
  bit   stall_en = 1'b0;
  int   stall_seen = 0;
  int   cyc = 0, rise_cnt = 0, sen_run = 0, last_sen_len = 0;
  int   high_run = 0, last_high = 0, done_cnt = 0, rd_cnt = 0;
  int   first_rise_cyc = 0, t_acc = 0, cur_h = 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_bits.push_back(v[i]);
  endtask

  task automatic push_read_word(input logic [DW-1:0] w);
    for (int i = DW - 1; i >= 0; i--) begin
      miso_bits.push_back(w[i]);
      exp_bits.push_back(1'b0);
    end
    exp_rd.push_back(w);
  endtask

  // One clock cycle: write-stream driver, slave model and monitors, sampled at negedge
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (hs_pending) begin
      hs_pending = 1'b0;
      void'(wr_words.pop_front());
      if (wr_words.size() > 0) i_wrData = wr_words[0];
      if (stall_en) begin
        i_wrValid = 1'b0;
        stall_en  = 1'b0;
      end
    end
    if (o_wrReady && !i_wrValid) begin
      if (stall_seen == STALL) i_wrValid = 1'b1;
      else stall_seen++;
    end
    hs_pending = o_wrReady && i_wrValid;
    if (o_wrReady) begin
      check("sck_low_in_waitwr", o_sck, 0);
      check("sen_low_in_waitwr", o_sen, 0);
    end
    if (o_sck && !prev_sck) begin
      rise_cnt++;
      if (rise_cnt == 1) first_rise_cyc = cyc;
      check("mosi_bit_expected", exp_bits.size() > 0, 1);
      if (exp_bits.size() > 0) check("mosi_bit", o_sdat, exp_bits.pop_front());
    end
    if (o_sck) high_run++;
    else if (prev_sck) begin
      last_high = high_run;
      high_run  = 0;
      if (rise_cnt >= HDR && miso_bits.size() > 0) i_sout = miso_bits.pop_front();
    end
    prev_sck = o_sck;
    if (!o_sen) sen_run++;
    else begin
      if (sen_run != 0) last_sen_len = sen_run;
      sen_run  = 0;
      rise_cnt = 0;
    end
    if (o_done) begin
      done_cnt++;
      check("done_with_sen_high", o_sen, 1);
    end
    if (o_rdValid) begin
      rd_cnt++;
      check("rd_word_expected", exp_rd.size() > 0, 1);
      if (exp_rd.size() > 0) check("rd_data", o_rdData, exp_rd.pop_front());
    end
  endtask

  task automatic start_cmd(input logic rd, input logic [AW-1:0] addr,
                           input logic [BW-1:0] bl, input logic [CW-1:0] div);
    i_read = rd; i_addr = addr; i_burstLen = bl; i_clkDiv = div; i_start = 1'b1;
    cur_h = int'(div) + 1;
    t_acc = cyc;
    exp_bits.push_back(rd);
    push_bits(32'(addr), AW);
    tick();
    i_start = 1'b0;
    check("sen_low_after_accept", o_sen, 0);
    check("busy_after_accept", o_busy, 1);
    check("sdat_header_msb", o_sdat, rd);
  endtask

  task automatic finish_frame(input int exp_sen, input int budget);
    int n;
    int d0;
    d0 = done_cnt;
    n = 0;
    while (!o_done && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", o_done, 1);
    n = 0;
    while (o_busy && n < cur_h + 5) begin
      tick();
      n++;
    end
    check("busy_fall_after_done", n, cur_h);
    check("done_once", done_cnt - d0, 1);
    check("sen_low_length", last_sen_len, exp_sen);
    check("first_sck_rise", first_rise_cyc - t_acc, cur_h + 1);
    check("mosi_all_shifted", exp_bits.size(), 0);
    check("rd_all_returned", exp_rd.size(), 0);
  endtask

  initial begin
    int r0, d0, n;
    rst_n = 1'b0;
    i_start = 0; i_read = 0; i_addr = '0; i_burstLen = '0; i_clkDiv = '0;
    i_wrData = '0; i_wrValid = 0; i_sout = 0;
    stall_seen = STALL;
    tick(); tick();
    check("rst_sen", o_sen, 1);
    check("rst_sck", o_sck, 0);
    check("rst_sdat", o_sdat, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_rdvalid", o_rdValid, 0);
    check("rst_wrready", o_wrReady, 0);
    check("rst_rddata", o_rdData, 0);
    rst_n = 1'b1;
    tick();

    // Single write, H=1, valid held high
    i_wrData = 8'hC3; i_wrValid = 1'b1; wr_words.push_back(8'hC3);
    start_cmd(1'b0, 7'h2A, 4'd0, 8'd0);
    push_bits(32'hC3, DW);
    finish_frame(33, 200);

    // Read burst of 3, H=4
    r0 = rd_cnt;
    start_cmd(1'b1, 7'h05, 4'd2, 8'd3);
    push_read_word(8'hA5); push_read_word(8'h3C); push_read_word(8'hFF);
    finish_frame(260, 2000);
    check("rd_pulses_3", rd_cnt - r0, 3);
    check("half_period_h4", last_high, 4);

    // Write burst of 2 with a 10-cycle stall before the second word
    wr_words.push_back(8'h11); wr_words.push_back(8'h22);
    i_wrData = 8'h11; i_wrValid = 1'b1; stall_en = 1'b1; stall_seen = 0;
    start_cmd(1'b0, 7'h15, 4'd1, 8'd0);
    push_bits(32'h11, DW); push_bits(32'h22, DW);
    finish_frame(59, 400);
    check("stall_cycles", stall_seen, STALL);

    // Start during busy is dropped; start right after busy falls is taken
    wr_words.push_back(8'h5A); i_wrData = 8'h5A; i_wrValid = 1'b1;
    start_cmd(1'b0, 7'h33, 4'd0, 8'd1);
    push_bits(32'h5A, DW);
    for (int i = 0; i < 5; i++) tick();
    i_read = 1'b1; i_addr = 7'h7F; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    finish_frame(66, 400);
    check("idle_busy_low", o_busy, 0);
    check("idle_sen_high", o_sen, 1);
    start_cmd(1'b1, 7'h11, 4'd0, 8'd1);
    push_read_word(8'h96);
    finish_frame(66, 400);

    // Slowest divider, longest burst
    r0 = rd_cnt;
    start_cmd(1'b1, 7'h4C, 4'hF, 8'hFF);
    for (int i = 0; i < 16; i++) push_read_word(8'((i * 37) ^ 8'h5A));
    finish_frame(69888, 80000);
    check("rd_pulses_16", rd_cnt - r0, 16);
    check("half_period_h256", last_high, 256);

    // Asynchronous reset in the middle of a read data word
    r0 = rd_cnt;
    d0 = done_cnt;
    start_cmd(1'b1, 7'h40, 4'd1, 8'd3);
    push_read_word(8'hF0); push_read_word(8'h0F);
    n = 0;
    while (rise_cnt < HDR + 4 && n < 1000) begin
      tick();
      n++;
    end
    check("reached_data_phase", rise_cnt, HDR + 4);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sen", o_sen, 1);
    check("async_rst_sck", o_sck, 0);
    check("async_rst_busy", o_busy, 0);
    exp_bits.delete(); exp_rd.delete(); miso_bits.delete();
    hs_pending = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2 * 4 * 4; i++) tick();
    check("no_done_after_abort", done_cnt - d0, 0);
    check("no_rdvalid_after_abort", rd_cnt - r0, 0);
    r0 = rd_cnt;
    start_cmd(1'b1, 7'h11, 4'd0, 8'd0);
    push_read_word(8'h5A);
    finish_frame(33, 200);
    check("rd_after_reset", rd_cnt - r0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
